// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and defaults for the writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;

    // Writeback request at the default widths.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Round-robin pointer: names the producer preferred on the next tie.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } arb_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// rtl/regfile_wb_arbiter_wb_scoreboard.sv - pending-destination busy vector
//
// Purpose: one busy bit per architectural register. A set marks a register as
// awaiting a result; a clear releases it when its result is accepted.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_en, set_idx          mark set_idx busy (wins over a same-index clear)
//   clr_en, clr_idx          release clr_idx
//   rd_idx0..2 / busy0..2    combinational reads of the current vector
module wb_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rd_idx0,
    input  logic [ADDR_WIDTH-1:0] rd_idx1,
    input  logic [ADDR_WIDTH-1:0] rd_idx2,
    output logic                  busy0,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        // Applied after the clear so a same-index set wins.
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        // x0 is never pending.
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Reads see the registered vector only; no bypass of a same-cycle set.
    assign busy0 = busy[rd_idx0];
    assign busy1 = busy[rd_idx1];
    assign busy2 = busy[rd_idx2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with scoreboard and forwarding
//
// Purpose: merges two execution producers onto the register file's single
// write port, tracks pending destinations for issue hazard checks, and
// forwards the registered in-flight write to the read side.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   iss_valid, iss_rd                 issue of an instruction writing iss_rd
//   rs1, rs2                          source indices read by issue
//   rs1_busy, rs2_busy, rd_busy       scoreboard bits for rs1/rs2/iss_rd
//   rs1_fwd_valid/data, rs2_fwd_*     in-flight write forwarded to rs1/rs2
//   a_valid/a_ready/a_rd/a_data       producer A (single-cycle ALU)
//   b_valid/b_ready/b_rd/b_data       producer B (multi-cycle LSU/MDU)
//   rf_wen, rf_waddr, rf_wdata        registered register file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    output logic                  rs1_fwd_valid,
    output logic                  rs2_fwd_valid,
    output logic [DATA_WIDTH-1:0] rs1_fwd_data,
    output logic [DATA_WIDTH-1:0] rs2_fwd_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    arb_ptr_e              ptr;
    logic                  grant_a;
    logic                  grant_b;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // The write path never stalls, so a lone valid is always granted and a
    // tie goes to the producer named by the pointer.
    always_comb begin
        grant_a = a_valid && (!b_valid || (ptr == PTR_A));
        grant_b = b_valid && (!a_valid || (ptr == PTR_B));
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign accept   = grant_a || grant_b;
    assign sel_rd   = grant_b ? b_rd   : a_rd;
    assign sel_data = grant_b ? b_data : a_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= PTR_A;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // Only a contested grant moves the pointer, to the loser.
            if (a_valid && b_valid) begin
                ptr <= grant_a ? PTR_B : PTR_A;
            end
            // An accept to x0 completes the handshake but never writes.
            rf_wen <= accept && (sel_rd != '0);
            if (accept) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (iss_valid),
        .set_idx (iss_rd),
        .clr_en  (accept),
        .clr_idx (sel_rd),
        .rd_idx0 (rs1),
        .rd_idx1 (rs2),
        .rd_idx2 (iss_rd),
        .busy0   (rs1_busy),
        .busy1   (rs2_busy),
        .busy2   (rd_busy)
    );

    // The busy bit drops at the accept edge but the register file only
    // captures one edge later; forwarding covers that gap.
    assign rs1_fwd_valid = rf_wen && (rf_waddr == rs1) && (rs1 != '0);
    assign rs2_fwd_valid = rf_wen && (rf_waddr == rs2) && (rs2 != '0);
    assign rs1_fwd_data  = rf_wdata;
    assign rs2_fwd_data  = rf_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        rs1_fwd_valid;
    logic        rs2_fwd_valid;
    logic [63:0] rs1_fwd_data;
    logic [63:0] rs2_fwd_data;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [63:0] b_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int      n_cmp = 0;
    int      n_err = 0;
    wb_req_t exp_q[$];
    logic    mptr;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rd_busy       (rd_busy),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check readies against the bench's own
    // arbitration model, queue the expected write, then step past the edge.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [63:0] bd,
                         input logic iv, input logic [4:0] ird,
                         output logic ga, output logic gb,
                         output logic obs_a, output logic obs_b);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird;
        #1;
        if (iv) chk("waw_rd_busy_at_issue", 64'(rd_busy), 64'd0);
        ga = av && (!bv || (mptr == 1'b0));
        gb = bv && (!av || (mptr == 1'b1));
        obs_a = a_ready;
        obs_b = b_ready;
        chk("a_ready", 64'(a_ready), 64'(ga));
        chk("b_ready", 64'(b_ready), 64'(gb));
        if (ga && ard != 5'd0) exp_q.push_back('{rd: ard, data: ad});
        if (gb && brd != 5'd0) exp_q.push_back('{rd: brd, data: bd});
        if (av && bv) mptr = ga ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Every write seen on the port must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && rf_wen) begin
            wb_req_t e;
            chk("write_was_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_waddr", 64'(rf_waddr), 64'(e.rd));
                chk("sb_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin : main
        logic ga, gb, oa, ob;
        int   ai, bi, aw, bw;

        rst = 1'b1; mptr = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_wen", 64'(rf_wen), 64'd0);
        chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_rf_wdata", rf_wdata, 64'd0);
        chk("reset_rs1_busy", 64'(rs1_busy), 64'd0);
        rst = 1'b0;

        // Lone producer A.
        drive(1, 5'd3, 64'hDEAD, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);
        chk("loneA_rf_wen", 64'(rf_wen), 64'd1);
        chk("loneA_rf_waddr", 64'(rf_waddr), 64'd3);
        chk("loneA_rf_wdata", rf_wdata, 64'hDEAD);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);
        chk("idle_rf_wen", 64'(rf_wen), 64'd0);
        chk("idle_wdata_hold", rf_wdata, 64'hDEAD);

        // Contention: A rd 1..4, B rd 9..12, each held until accepted.
        ai = 0; bi = 0; aw = 0; bw = 0;
        for (int c = 0; c < 8; c++) begin
            drive(ai < 4, 5'(1 + ai), 64'hA0 + 64'(ai),
                  bi < 4, 5'(9 + bi), 64'hB0 + 64'(bi),
                  0, 5'd0, ga, gb, oa, ob);
            aw = (ai < 4 && !oa) ? aw + 1 : 0;
            bw = (bi < 4 && !ob) ? bw + 1 : 0;
            chk("a_wait_le1", 64'(aw <= 1), 64'd1);
            chk("b_wait_le1", 64'(bw <= 1), 64'd1);
            if (ga) ai++;
            if (gb) bi++;
        end
        chk("contention_all_a", 64'(ai), 64'd4);
        chk("contention_all_b", 64'(bi), 64'd4);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);

        // Scoreboard set then B clears with forwarding.
        rs1 = 5'd7; rs2 = 5'd7;
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7, ga, gb, oa, ob);
        chk("sb7_rd_busy", 64'(rd_busy), 64'd1);
        chk("sb7_rs1_busy", 64'(rs1_busy), 64'd1);
        drive(0, 5'd0, 64'd0, 1, 5'd7, 64'h55, 0, 5'd7, ga, gb, oa, ob);
        chk("clr7_rs1_busy", 64'(rs1_busy), 64'd0);
        chk("fwd7_rs1_valid", 64'(rs1_fwd_valid), 64'd1);
        chk("fwd7_rs1_data", rs1_fwd_data, 64'h55);
        chk("fwd7_rs2_valid", 64'(rs2_fwd_valid), 64'd1);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);
        chk("fwd7_gone", 64'(rs1_fwd_valid), 64'd0);

        // Set and clear of the same index in one cycle: set wins.
        rs1 = 5'd4;
        drive(1, 5'd4, 64'h44, 0, 5'd0, 64'd0, 1, 5'd4, ga, gb, oa, ob);
        chk("coll_rs1_busy", 64'(rs1_busy), 64'd1);
        chk("coll_rf_wen", 64'(rf_wen), 64'd1);
        chk("coll_rf_waddr", 64'(rf_waddr), 64'd4);

        // x0: handshake completes, no write, never busy, never forwarded.
        rs1 = 5'd0;
        drive(1, 5'd0, 64'hFF, 0, 5'd0, 64'd0, 1, 5'd0, ga, gb, oa, ob);
        chk("x0_a_ready", 64'(oa), 64'd1);
        chk("x0_rf_wen", 64'(rf_wen), 64'd0);
        chk("x0_rs1_busy", 64'(rs1_busy), 64'd0);
        chk("x0_rs1_fwd", 64'(rs1_fwd_valid), 64'd0);

        // Reset in the middle of a write with a pending busy bit.
        rs1 = 5'd5;
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd5, ga, gb, oa, ob);
        drive(1, 5'd9, 64'h5555, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);
        chk("prerst_rf_wen", 64'(rf_wen), 64'd1);
        chk("prerst_rs1_busy", 64'(rs1_busy), 64'd1);
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h5;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_async_rf_wdata", rf_wdata, 64'd0);
        chk("rst_async_busy5", 64'(rs1_busy), 64'd0);
        // The interrupted write was already checked directly above.
        exp_q.delete();
        mptr = 1'b0;
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, ga, gb, oa, ob);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
